tti_rx_queue: RTL
=================

// Module: tti_rx_queue
// PURPOSE
// - Target-side RX FIFO between the I3C target bus FSM (producer) and the TTI CSR front-end (consumer).
// - Used twice: once as the RX descriptor queue, once as the RX data queue.
// - Produces the CSR read-port ack/data, threshold clamp/trigger, full/empty flags, write monitor
//   and self-clearing register-reset handshake consumed by the TTI block.
// PARAMETERS
// - Depth      64  number of entries; power of two, >= 4
// - DataWidth  32  entry width in bits
// - ThldWidth   8  width of ready-threshold field
// PORTS
// - clk_i          in   1          clock
// - rst_ni         in   1          asynchronous active-low reset
// - wvalid_i       in   1          producer entry valid
// - wready_o       out  1          queue can accept an entry
// - wdata_i        in   DataWidth  producer entry
// - write_o        out  1          pulse: entry accepted this cycle (write monitor)
// - rreq_i         in   1          single-cycle CSR read strobe
// - rack_o         out  1          single-cycle read acknowledge
// - rdata_o        out  DataWidth  read data, valid with rack_o
// - underflow_o    out  1          pulse with rack_o when the read hit an empty queue
// - ready_thld_i   in   ThldWidth  software-programmed ready threshold
// - ready_thld_o   out  ThldWidth  clamped threshold, written back to CSR
// - ready_thld_trig_o out 1        occupancy >= threshold
// - reg_rst_i      in   1          CSR queue-reset bit value
// - reg_rst_we_o   out  1          write enable to clear the CSR reset bit
// - reg_rst_data_o out  1          value written to the CSR reset bit (always 0)
// - empty_o        out  1          queue empty
// - full_o         out  1          queue full
// BEHAVIOUR
// - Reset values: count/pointers = 0; empty_o = 1; full_o = 0; wready_o = 1.
//   All other outputs are 0 at reset, including rack_o, rdata_o, write_o, trig, reg_rst_we_o and underflow_o.
// - Occupancy
//   - count is $clog2(Depth+1) bits.
//   - empty_o, full_o and ready_thld_trig_o are registered.
//   - They reflect count one cycle after the write/read that changed it, aligned with write_o delayed by 1.
// - Write
//   - wready_o = !full_o && !reg_rst_i.
//   - Accept when wvalid_i && wready_o; write_o pulses in the same cycle.
// - Read
//   - On rreq_i, if count != 0: pop head; rack_o = 1 and rdata_o = head on the next cycle.
//   - If count == 0: next cycle rack_o = 1, rdata_o = 0, underflow_o = 1. The CSR bus never stalls.
//   - rdata_o returns to 0 when rack_o = 0.
// - Simultaneous read and write
//   - Same cycle, count > 0: both happen; count unchanged.
//   - Empty: no bypass. The read underflows and the write is stored.
//   - Full: the write is refused, because wready_o was already 0 that cycle.
// - Threshold
//   - ready_thld_o = (ready_thld_i >= Depth) ? Depth-1 : ready_thld_i (combinational).
//   - trig = (thld_o != 0) && (count >= thld_o). Threshold 0 never triggers.
// - Register reset
//   - While reg_rst_i = 1: the cycle after it is seen, pointers and count go to 0 (empty_o = 1).
//   - In that same cycle reg_rst_we_o pulses 1 for one cycle with reg_rst_data_o = 0, clearing the bit.
//   - Writes are blocked while reg_rst_i = 1.
//   - A read strobed in the flush cycle is acked next cycle with rdata_o = 0 and underflow_o = 1.
// - Pointers wrap modulo Depth; the full/empty distinction comes from count, not from pointer equality.
// - Asynchronous reset mid-transfer: any pending ack is dropped and everything returns to reset values.
// STRUCTURE
// - i3c_pkg holds the default constants: TtiRxDescDepth, TtiRxDataDepth, TtiThldWidth.
// - One sub-module, tti_queue_mem: flop array plus write/read pointers with wrap.
//   It exposes push, pop, wdata and head.
// - Occupancy, flag, threshold, read-ack and reset-handshake logic live in tti_rx_queue.
// TESTING
// - Basic order: Depth=4; write A1,A2,A3; three rreq_i strobes.
//   -> rack_o one cycle after each strobe with A1, A2, A3; empty_o = 1 after the last.
// - Full: 4 writes, then a 5th wvalid_i.
//   -> full_o = 1 and wready_o = 0; 5th not accepted, write_o stays 0; read returns the 1st entry.
// - Threshold: ready_thld_i = 9 with Depth=4 -> ready_thld_o = 3.
//   Write 3 entries -> trig = 1 one cycle after the 3rd write_o. Read 1 -> trig = 0.
// - Empty read: rreq_i with count = 0 -> next cycle rack_o = 1, rdata_o = 0, underflow_o = 1.
// - Register reset: hold 2 entries; set reg_rst_i = 1 with a concurrent wvalid_i.
//   -> write refused; next cycle empty_o = 1, reg_rst_we_o = 1, reg_rst_data_o = 0.
// - Wrap and simultaneous: 10 cycles of concurrent write and read at count = 2.
//   -> data order preserved across the pointer wrap; count stays 2.

Source files
------------

// File: rtl/i3c_pkg.sv
// ============================================================================
// | Module   : i3c_pkg                                                       |
// | Purpose  : Shared default sizing constants for the I3C target TTI        |
// |            queues.                                                       |
// | Contents : TtiRxDescDepth - default RX descriptor queue depth            |
// |            TtiRxDataDepth - default RX data queue depth                  |
// |            TtiThldWidth   - width of the ready-threshold CSR field       |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

package i3c_pkg;

  localparam int TtiRxDescDepth = 64;
  localparam int TtiRxDataDepth = 64;
  localparam int TtiThldWidth   = 8;

endpackage

`default_nettype wire

// File: rtl/tti_queue_mem.sv
// ============================================================================
// | Module   : tti_queue_mem                                                 |
// | Purpose  : Flop-array storage with wrapping write/read pointers.         |
// | Ports    : clk_i   - clock                                               |
// |            rst_ni  - asynchronous active-low reset                       |
// |            flush   - synchronous pointer clear (queue register reset)    |
// |            push    - store wdata at the write pointer                    |
// |            pop     - advance the read pointer                            |
// |            wdata   - entry to store                                      |
// |            head    - entry at the read pointer                           |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module tti_queue_mem #(
  parameter int Depth     = 64,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] head
);

  localparam int PtrWidth = $clog2(Depth);

  logic [PtrWidth-1:0]  wptr;
  logic [PtrWidth-1:0]  rptr;
  logic [DataWidth-1:0] mem [Depth];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PtrWidth'(1);
      if (pop)  rptr <= rptr + PtrWidth'(1);
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];

endmodule

`default_nettype wire

// File: rtl/tti_rx_queue.sv
// ============================================================================
// | Module   : tti_rx_queue                                                  |
// | Purpose  : Target-side RX FIFO between the I3C bus FSM (producer) and    |
// |            the TTI CSR front-end (consumer). Provides a never-stalling   |
// |            CSR read port, threshold clamp/trigger, flags, a write        |
// |            monitor and a self-clearing queue-reset handshake.            |
// | Ports    : clk_i/rst_ni          - clock, async active-low reset         |
// |            wvalid_i/wready_o     - producer handshake, wdata_i entry     |
// |            write_o               - entry accepted this cycle             |
// |            rreq_i                - single-cycle CSR read strobe          |
// |            rack_o/rdata_o        - read ack and data (next cycle)        |
// |            underflow_o           - read hit an empty queue               |
// |            ready_thld_i/_o       - programmed / clamped threshold        |
// |            ready_thld_trig_o     - occupancy >= clamped threshold        |
// |            reg_rst_i             - CSR queue-reset bit                   |
// |            reg_rst_we_o/_data_o  - clears the CSR queue-reset bit        |
// |            empty_o/full_o        - registered occupancy flags            |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module tti_rx_queue
  import i3c_pkg::*;
#(
  parameter int Depth     = TtiRxDataDepth,
  parameter int DataWidth = 32,
  parameter int ThldWidth = TtiThldWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 write_o,
  input  logic                 rreq_i,
  output logic                 rack_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 underflow_o,
  input  logic [ThldWidth-1:0] ready_thld_i,
  output logic [ThldWidth-1:0] ready_thld_o,
  output logic                 ready_thld_trig_o,
  input  logic                 reg_rst_i,
  output logic                 reg_rst_we_o,
  output logic                 reg_rst_data_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int CntWidth = $clog2(Depth + 1);

  logic [CntWidth-1:0]  count;
  logic [CntWidth-1:0]  count_next;
  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] head;

  // Writes are refused for the whole time the CSR reset bit is set.
  assign wready_o = !full_o && !reg_rst_i;
  assign push     = wvalid_i && wready_o;
  assign write_o  = push;

  // A read during a flush cycle is treated as a read of an empty queue.
  assign pop = rreq_i && (count != '0) && !reg_rst_i;

  assign ready_thld_o = (32'(ready_thld_i) >= 32'(Depth)) ? ThldWidth'(Depth - 1)
                                                          : ready_thld_i;

  assign reg_rst_data_o = 1'b0;

  always_comb begin
    count_next = count;
    if (reg_rst_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CntWidth'(1);
        2'b01:   count_next = count - CntWidth'(1);
        default: count_next = count;
      endcase
    end
  end

  // Flags are computed from count_next so they track the count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count             <= '0;
      empty_o           <= 1'b1;
      full_o            <= 1'b0;
      ready_thld_trig_o <= 1'b0;
      rack_o            <= 1'b0;
      rdata_o           <= '0;
      underflow_o       <= 1'b0;
      reg_rst_we_o      <= 1'b0;
    end else begin
      count             <= count_next;
      empty_o           <= (count_next == '0);
      full_o            <= (count_next == CntWidth'(Depth));
      ready_thld_trig_o <= (ready_thld_o != '0) &&
                           (32'(count_next) >= 32'(ready_thld_o));
      rack_o            <= rreq_i;
      rdata_o           <= pop ? head : '0;
      underflow_o       <= rreq_i && !pop;
      // One pulse per reset request; the CSR bit clears on that pulse, so a
      // bit still seen high in the following cycle must not re-trigger it.
      reg_rst_we_o      <= reg_rst_i && !reg_rst_we_o;
    end
  end

  tti_queue_mem #(
    .Depth     (Depth),
    .DataWidth (DataWidth)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (reg_rst_i),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata_i),
    .head   (head)
  );

endmodule

`default_nettype wire
